// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : constants shared by the fetch, decode and hazard stages
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int unsigned    ADDR_W_DEFAULT   = 32;
  localparam int unsigned    INSTR_W_DEFAULT  = 32;
  localparam logic [31:0]    INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0]    PC_INC           = 32'd4;
  localparam logic [31:0]    RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_full) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = r_cnt;

endmodule : sat_counter

`default_nettype wire

// File: rtl/ifetch_stage.sv
// ============================================================================
// ifetch_stage : PC register, next-PC selection, IF/ID register, perf counters
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ifetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned        INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0],
  parameter int unsigned        CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pcwrite_i,
  input  logic               ifid_write_i,
  input  logic               ifid_flush_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam logic [ADDR_W-1:0]  c_pc_inc = PC_INC[ADDR_W-1:0];
  localparam logic [INSTR_W-1:0] c_nop    = INSTR_NOP[INSTR_W-1:0];

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_ifid_pc4;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic               r_ifid_valid;
  logic               r_misalign;

  logic [ADDR_W-1:0]  w_pc_plus4;
  logic [ADDR_W-1:0]  w_target_aligned;
  logic               w_stall_evt;

  assign w_pc_plus4       = r_pc + c_pc_inc;
  assign w_target_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};
  // A redirect cycle is not counted as a stall even when pcwrite is low.
  assign w_stall_evt      = !pcwrite_i && !branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_PC;
    end else if (branch_taken_i) begin
      r_pc <= w_target_aligned;
    end else if (pcwrite_i) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
    end else if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid_pc4   <= '0;
      r_ifid_instr <= c_nop;
      r_ifid_valid <= 1'b0;
    end else if (ifid_flush_i) begin
      r_ifid_pc4   <= '0;
      r_ifid_instr <= c_nop;
      r_ifid_valid <= 1'b0;
    end else if (ifid_write_i) begin
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= imem_instr_i;
      r_ifid_valid <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_evt),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifid_flush_i),
    .cnt_o (flush_cnt_o)
  );

  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_valid_o = r_ifid_valid;
  assign misalign_o   = r_misalign;

endmodule : ifetch_stage

`default_nettype wire

// File: tb/tb_ifetch_stage.sv
// ============================================================================
// tb_ifetch_stage : scoreboard bench for ifetch_stage against a reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [1:0]  stall2;
    logic [1:0]  flush2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pcwrite, ifid_write, ifid_flush, branch_taken;
  logic [31:0] branch_target;

  logic [31:0] imem_addr, imem_instr, pc, ifid_pc4, ifid_instr;
  logic        ifid_valid, misalign;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] imem_addr2, imem_instr2, pc2, ifid_pc42, ifid_instr2;
  logic        ifid_valid2, misalign2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t m;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_instr  = mem(imem_addr);
  assign imem_instr2 = mem(imem_addr2);

  ifetch_stage dut (
    .clk_i(clk), .rst_i(rst_n), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .imem_addr_o(imem_addr),
    .imem_instr_i(imem_instr), .pc_o(pc), .ifid_pc4_o(ifid_pc4),
    .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid), .misalign_o(misalign),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  ifetch_stage #(.CNT_W(2)) dut_c2 (
    .clk_i(clk), .rst_i(rst_n), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .imem_addr_o(imem_addr2),
    .imem_instr_i(imem_instr2), .pc_o(pc2), .ifid_pc4_o(ifid_pc42),
    .ifid_instr_o(ifid_instr2), .ifid_valid_o(ifid_valid2), .misalign_o(misalign2),
    .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.pc4 = 32'h0; m.instr = 32'h0; m.valid = 1'b0; m.mis = 1'b0;
    m.stall = 16'd0; m.flush = 16'd0; m.stall2 = 2'd0; m.flush2 = 2'd0;
  endtask

  task automatic check_reset_outputs();
    check("rst_pc", pc, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_pc4", ifid_pc4, 0);
    check("rst_instr", ifid_instr, 0);
    check("rst_valid", ifid_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_stall_cnt_c2", stall_cnt2, 0);
  endtask

  // Called at a falling edge: apply inputs, predict the state after the next rising edge.
  task automatic step(input logic pw, input logic iw, input logic fl,
                      input logic br, input logic [31:0] tgt);
    pcwrite = pw; ifid_write = iw; ifid_flush = fl;
    branch_taken = br; branch_target = tgt;
    if (fl) begin
      m.instr = 32'h0; m.pc4 = 32'h0; m.valid = 1'b0;
    end else if (iw) begin
      m.instr = mem(m.pc); m.pc4 = m.pc + 32'd4; m.valid = 1'b1;
    end
    if (br) begin
      if (tgt % 4 != 0) m.mis = 1'b1;
      m.pc = tgt - (tgt % 4);
    end else if (pw) begin
      m.pc = m.pc + 32'd4;
    end
    if (!pw && !br) begin
      if (m.stall  != 16'hFFFF) m.stall++;
      if (m.stall2 != 2'd3)     m.stall2++;
    end
    if (fl) begin
      if (m.flush  != 16'hFFFF) m.flush++;
      if (m.flush2 != 2'd3)     m.flush2++;
    end
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  // Monitor: outputs are valid every cycle after a stimulus step; compare then.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("imem_addr", imem_addr, e.pc);
        check("ifid_pc4", ifid_pc4, e.pc4);
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_valid", ifid_valid, e.valid);
        check("misalign", misalign, e.mis);
        check("stall_cnt", stall_cnt, e.stall);
        check("flush_cnt", flush_cnt, e.flush);
        check("stall_cnt_c2", stall_cnt2, e.stall2);
        check("flush_cnt_c2", flush_cnt2, e.flush2);
        check("pc_c2", pc2, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b1;
    pcwrite = 0; ifid_write = 0; ifid_flush = 0; branch_taken = 0; branch_target = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch up to PC 0x10, then a two-cycle stall and resume.
    repeat (4) step(1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    // Redirect with flush, then capture at the target.
    step(1, 1, 1, 1, 32'h40);
    step(1, 1, 0, 0, 0);
    // Redirect beats stall; misaligned target sets the sticky flag.
    step(0, 1, 0, 1, 32'h81);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    // Wraparound from the last aligned address.
    step(1, 1, 0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 0);
    // Stall and flush saturation on the narrow counter; flush beats write.
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (5) step(1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);

    repeat (400) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, t);
    end

    // Asynchronous reset between edges in the middle of a stall.
    step(0, 0, 0, 0, 0);
    pcwrite = 0; ifid_write = 0; ifid_flush = 1; branch_taken = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1, 1, 0, 0, 0);
    repeat (40) step($urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ifetch_stage

`default_nettype wire
